// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction word stream into the loader and the
// byte-wide write port it drives into instruction memory.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into byte-wide imem,
// LSB first, stalling the core and flagging unsupported opcodes.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  words_written,
    imem_loader_if.slave      bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int SUM_W = ADDR_W + 2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       data_q;
    logic [1:0]        idx;

    logic [SUM_W-1:0]  end_addr;
    logic              args_ok;
    logic              op_ok;

    // End of region is computed two bits wider so it cannot wrap.
    assign end_addr = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
    assign args_ok  = (base_addr[1:0] == 2'b00)
                   && (word_count != '0)
                   && (end_addr <= (SUM_W'(1) << ADDR_W));

    assign op_ok = bus.in_data[6:0] inside {
        7'b0110011, 7'b0010011, 7'b0000011,
        7'b0100011, 7'b1100011
    };

    assign bus.in_ready = (state == S_ACCEPT);
    assign busy         = (state == S_ACCEPT) || (state == S_WRITE);
    assign done         = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cur           <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            idx           <= '0;
            error         <= 1'b0;
            illegal_op    <= 1'b0;
            words_written <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            error      <= 1'b0;
            bus.mem_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (args_ok) begin
                            cur           <= base_addr;
                            cnt_q         <= word_count;
                            words_written <= '0;
                            illegal_op    <= 1'b0;
                            state         <= S_ACCEPT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (bus.in_valid) begin
                        data_q <= bus.in_data;
                        idx    <= '0;
                        state  <= S_WRITE;
                        if (!op_ok) illegal_op <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= cur + ADDR_W'(idx);
                        bus.mem_wdata <= data_q[{idx, 3'b000} +: 8];
                        idx           <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            cur           <= cur + ADDR_W'(4);
                            words_written <= words_written + 1'b1;
                            state <= (words_written + 1'b1 == cnt_q)
                                   ? S_DONE : S_ACCEPT;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
